// File: rtl/food_placer_if.sv
// food_placer_if -- bundle between the food placer, the logic datapath that
// requests placements and the PRNG datapath that supplies random cell indices.
// master: the surrounding datapaths; slave: the food placer itself.
interface food_placer_if;
   logic        place_req;
   logic [63:0] occupancy_flat;
   logic        prng_req;
   logic        prng_ack;
   logic [5:0]  prng_value;
   logic [2:0]  food_row;
   logic [2:0]  food_col;
   logic        food_valid;
   logic        place_done;
   logic        board_full;

   modport master (
      output place_req,
      output occupancy_flat,
      output prng_ack,
      output prng_value,
      input  prng_req,
      input  food_row,
      input  food_col,
      input  food_valid,
      input  place_done,
      input  board_full
   );

   modport slave (
      input  place_req,
      input  occupancy_flat,
      input  prng_ack,
      input  prng_value,
      output prng_req,
      output food_row,
      output food_col,
      output food_valid,
      output place_done,
      output board_full
   );
endinterface

// File: rtl/food_placer.sv
// food_placer -- picks a free 8x8 board cell for new food.
// Draws up to MAX_RETRIES random indices from the PRNG datapath; if all of
// them land on the snake it falls back to a linear scan starting just after
// the last draw. An all-occupied board is detected up front so the scan
// always terminates.
// Optional feature macro FOOD_PRNG_TIMEOUT_EN: abandon a PRNG wait after 16
// cycles without an ack and scan from index 0 instead.
// All outputs are registered; they are loaded from the next-state decode so
// they line up exactly with the state they describe.
module food_placer #(
   parameter int MAX_RETRIES = 8
) (
   input  logic         clka,
   input  logic         restart,
   food_placer_if.slave bus
);

   localparam logic [3:0] MAX_RETRIES_C = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_PRNG = 3'd1,
      CHECK     = 3'd2,
      SCAN      = 3'd3,
      DONE      = 3'd4,
      FULL      = 3'd5
   } state_t;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [5:0] cand_r;
   logic [5:0] cand_nxt_s;
   logic [5:0] scan_idx_r;
   logic [5:0] scan_idx_nxt_s;
   logic [3:0] retry_r;
   logic [3:0] retry_nxt_s;
   logic [3:0] retry_inc_s;
   logic [5:0] pick_idx_s;

   logic       prng_req_r;
   logic       place_done_r;
   logic       food_valid_r;
   logic       food_valid_nxt_s;
   logic       board_full_r;
   logic       board_full_nxt_s;
   logic [2:0] food_row_r;
   logic [2:0] food_row_nxt_s;
   logic [2:0] food_col_r;
   logic [2:0] food_col_nxt_s;

`ifdef FOOD_PRNG_TIMEOUT_EN
   logic [4:0] wait_cnt_r;
   logic [4:0] wait_cnt_nxt_s;
`endif

   // Cell lookup: bit index is row*8+col, row 0 in the LSB byte.
   function automatic logic cell_occupied(input logic [63:0] occ, input logic [5:0] idx);
      return occ[idx];
   endfunction

   // Next board index; wraps 63 -> 0 through the natural 6-bit overflow.
   function automatic logic [5:0] idx_next(input logic [5:0] idx);
      return idx + 6'd1;
   endfunction

   // Next-state and next-value decode for the FSM and its datapath.
   always_comb begin
      state_nxt_s      = state_r;
      cand_nxt_s       = cand_r;
      scan_idx_nxt_s   = scan_idx_r;
      retry_nxt_s      = retry_r;
      retry_inc_s      = retry_r + 4'd1;
      pick_idx_s       = scan_idx_r;
      food_valid_nxt_s = food_valid_r;
      board_full_nxt_s = board_full_r;
      food_row_nxt_s   = food_row_r;
      food_col_nxt_s   = food_col_r;
`ifdef FOOD_PRNG_TIMEOUT_EN
      wait_cnt_nxt_s   = wait_cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (bus.place_req) begin
               food_valid_nxt_s = 1'b0;
               retry_nxt_s      = 4'd0;
               if (&bus.occupancy_flat) begin
                  state_nxt_s      = FULL;
                  board_full_nxt_s = 1'b1;
               end else begin
                  state_nxt_s      = WAIT_PRNG;
                  board_full_nxt_s = 1'b0;
`ifdef FOOD_PRNG_TIMEOUT_EN
                  wait_cnt_nxt_s   = 5'd0;
`endif
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT_PRNG: begin
            if (bus.prng_ack) begin
               cand_nxt_s  = bus.prng_value;
               state_nxt_s = CHECK;
`ifdef FOOD_PRNG_TIMEOUT_EN
            end else if (wait_cnt_r == 5'd15) begin
               // 16th silent cycle: give up on the PRNG and sweep the board.
               state_nxt_s    = SCAN;
               scan_idx_nxt_s = 6'd0;
            end else begin
               wait_cnt_nxt_s = wait_cnt_r + 5'd1;
            end
`else
            end else begin
               state_nxt_s = WAIT_PRNG;
            end
`endif
         end
         CHECK: begin
            pick_idx_s = cand_r;
            if (!cell_occupied(bus.occupancy_flat, cand_r)) begin
               state_nxt_s    = DONE;
               food_row_nxt_s = cand_r[5:3];
               food_col_nxt_s = cand_r[2:0];
            end else begin
               retry_nxt_s = retry_inc_s;
               if (retry_inc_s == MAX_RETRIES_C) begin
                  state_nxt_s    = SCAN;
                  scan_idx_nxt_s = idx_next(cand_r);
               end else begin
                  state_nxt_s = WAIT_PRNG;
`ifdef FOOD_PRNG_TIMEOUT_EN
                  wait_cnt_nxt_s = 5'd0;
`endif
               end
            end
         end
         SCAN: begin
            if (!cell_occupied(bus.occupancy_flat, scan_idx_r)) begin
               state_nxt_s    = DONE;
               food_row_nxt_s = pick_idx_s[5:3];
               food_col_nxt_s = pick_idx_s[2:0];
            end else begin
               scan_idx_nxt_s = idx_next(scan_idx_r);
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         FULL: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
      if (state_nxt_s == DONE) begin
         food_valid_nxt_s = 1'b1;
      end else begin
         food_valid_nxt_s = food_valid_nxt_s;
      end
   end

   // State register with synchronous restart.
   always_ff @(posedge clka) begin
      if (restart) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath and output registers, loaded from the next-state decode.
   always_ff @(posedge clka) begin
      if (restart) begin
         cand_r       <= 6'd0;
         scan_idx_r   <= 6'd0;
         retry_r      <= 4'd0;
         prng_req_r   <= 1'b0;
         place_done_r <= 1'b0;
         food_valid_r <= 1'b0;
         board_full_r <= 1'b0;
         food_row_r   <= 3'd0;
         food_col_r   <= 3'd0;
      end else begin
         cand_r       <= cand_nxt_s;
         scan_idx_r   <= scan_idx_nxt_s;
         retry_r      <= retry_nxt_s;
         prng_req_r   <= (state_nxt_s == WAIT_PRNG);
         place_done_r <= (state_nxt_s == DONE) || (state_nxt_s == FULL);
         food_valid_r <= food_valid_nxt_s;
         board_full_r <= board_full_nxt_s;
         food_row_r   <= food_row_nxt_s;
         food_col_r   <= food_col_nxt_s;
      end
   end

`ifdef FOOD_PRNG_TIMEOUT_EN
   // PRNG wait counter, cleared whenever WAIT_PRNG is entered.
   always_ff @(posedge clka) begin
      if (restart) begin
         wait_cnt_r <= 5'd0;
      end else begin
         wait_cnt_r <= wait_cnt_nxt_s;
      end
   end
`endif

   assign bus.prng_req   = prng_req_r;
   assign bus.place_done = place_done_r;
   assign bus.food_valid = food_valid_r;
   assign bus.board_full = board_full_r;
   assign bus.food_row   = food_row_r;
   assign bus.food_col   = food_col_r;

endmodule

// File: tb/tb_food_placer.sv
// tb_food_placer -- directed scoreboard bench for food_placer.
// dut_a uses the default MAX_RETRIES, dut_b uses MAX_RETRIES=2; a select
// line routes the shared stimulus to one of them and muxes its outputs to
// the monitor. Expected completions are queued when a request is issued and
// checked by the monitor whenever place_done is seen.
module tb_food_placer;

   logic        clka = 1'b0;
   logic        restart;
   logic        place_req;
   logic        prng_ack;
   logic [5:0]  prng_value;
   logic [63:0] occ;
   logic        sel;

   // Free-running clock.
   always #5 clka = ~clka;

   food_placer_if bus_a ();
   food_placer_if bus_b ();

   food_placer dut_a (.clka(clka), .restart(restart), .bus(bus_a));
   food_placer #(.MAX_RETRIES(2)) dut_b (.clka(clka), .restart(restart), .bus(bus_b));

   assign bus_a.place_req      = place_req & ~sel;
   assign bus_a.occupancy_flat = occ;
   assign bus_a.prng_ack       = prng_ack & ~sel;
   assign bus_a.prng_value     = prng_value;
   assign bus_b.place_req      = place_req & sel;
   assign bus_b.occupancy_flat = occ;
   assign bus_b.prng_ack       = prng_ack & sel;
   assign bus_b.prng_value     = prng_value;

   logic       prng_req_m;
   logic       place_done_m;
   logic       food_valid_m;
   logic       board_full_m;
   logic [2:0] food_row_m;
   logic [2:0] food_col_m;
   assign prng_req_m   = sel ? bus_b.prng_req   : bus_a.prng_req;
   assign place_done_m = sel ? bus_b.place_done : bus_a.place_done;
   assign food_valid_m = sel ? bus_b.food_valid : bus_a.food_valid;
   assign board_full_m = sel ? bus_b.board_full : bus_a.board_full;
   assign food_row_m   = sel ? bus_b.food_row   : bus_a.food_row;
   assign food_col_m   = sel ? bus_b.food_col   : bus_a.food_col;

   typedef struct {
      string      name;
      logic [2:0] row;
      logic [2:0] col;
      logic       chk_pos;
      logic       valid;
      logic       full;
      int         nreq;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   req_cnt = 0;
   logic req_prev = 1'b0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: counts prng_req handshakes and scores every place_done.
   always @(negedge clka) begin
      exp_t e;
      if (restart === 1'b1) begin
         req_cnt = 0;
      end else if (prng_req_m === 1'b1 && req_prev !== 1'b1) begin
         req_cnt++;
      end
      req_prev = prng_req_m;
      if (place_done_m === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_place_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            if (e.chk_pos) begin
               check({e.name, "_row"}, 64'(food_row_m), 64'(e.row));
               check({e.name, "_col"}, 64'(food_col_m), 64'(e.col));
            end
            check({e.name, "_valid"}, 64'(food_valid_m), 64'(e.valid));
            check({e.name, "_full"}, 64'(board_full_m), 64'(e.full));
            check({e.name, "_handshakes"}, 64'(req_cnt), 64'(e.nreq));
         end
         req_cnt = 0;
      end
   end

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic expect_done(string name, logic [2:0] row, logic [2:0] col,
                              logic chk_pos, logic valid, logic full, int nreq);
      exp_t e;
      e.name = name; e.row = row; e.col = col; e.chk_pos = chk_pos;
      e.valid = valid; e.full = full; e.nreq = nreq;
      sb.push_back(e);
   endtask

   // Raise place_req for exactly one edge; returns #1 after that edge.
   task automatic request(logic [63:0] o);
      @(negedge clka);
      occ = o;
      place_req = 1'b1;
      tick();
      place_req = 1'b0;
   endtask

   task automatic wait_req(string name);
      int n = 0;
      while (prng_req_m !== 1'b1 && n < 200) begin
         @(negedge clka);
         n++;
      end
      if (n >= 200) check({name, "_req_timeout"}, 64'd0, 64'd1);
   endtask

   // Answer the pending PRNG request with one ack strobe.
   task automatic serve(string name, logic [5:0] v);
      wait_req(name);
      prng_ack = 1'b1;
      prng_value = v;
      tick();
      prng_ack = 1'b0;
   endtask

   task automatic wait_done(string name);
      int n = 0;
      while (place_done_m !== 1'b1 && n < 200) begin
         @(negedge clka);
         n++;
      end
      if (n >= 200) check({name, "_done_timeout"}, 64'd0, 64'd1);
      tick();
   endtask

   // Directed stimulus sequence.
   initial begin
      restart = 1'b1; place_req = 1'b0; prng_ack = 1'b0;
      prng_value = 6'd0; occ = 64'd0; sel = 1'b0;
      repeat (3) tick();
      restart = 1'b0;
      tick();

      // Reset state of both instances
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check($sformatf("rst%0d_prng_req", s),   64'(prng_req_m),   64'd0);
         check($sformatf("rst%0d_place_done", s), 64'(place_done_m), 64'd0);
         check($sformatf("rst%0d_food_valid", s), 64'(food_valid_m), 64'd0);
         check($sformatf("rst%0d_board_full", s), 64'(board_full_m), 64'd0);
         check($sformatf("rst%0d_food_row", s),   64'(food_row_m),   64'd0);
         check($sformatf("rst%0d_food_col", s),   64'(food_col_m),   64'd0);
      end
      sel = 1'b0;
      tick();

      // Empty board, draw 19 -> row 2 col 3, latency check
      expect_done("empty19", 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 1);
      request(64'd0);
      check("lat_req_high_n1", 64'(prng_req_m), 64'd1);
      serve("empty19", 6'd19);
      check("lat_req_low_after_ack", 64'(prng_req_m), 64'd0);
      check("lat_no_done_in_check", 64'(place_done_m), 64'd0);
      tick();
      check("lat_done_k2", 64'(place_done_m), 64'd1);
      tick();
      check("done_one_cycle", 64'(place_done_m), 64'd0);
      repeat (3) tick();
      check("hold_valid", 64'(food_valid_m), 64'd1);
      check("hold_row", 64'(food_row_m), 64'd2);

      // Bits 5 and 9 occupied, draws 5, 9, 12 -> index 12
      expect_done("retry12", 3'd1, 3'd4, 1'b1, 1'b1, 1'b0, 3);
      request(64'h0000_0000_0000_0220);
      serve("retry12_a", 6'd5);
      serve("retry12_b", 6'd9);
      serve("retry12_c", 6'd12);
      wait_done("retry12");

      // Restart with a simultaneous ack in WAIT_PRNG
      request(64'h0000_0000_0000_0220);
      wait_req("rst_mid");
      prng_ack = 1'b1; prng_value = 6'd7; restart = 1'b1;
      tick();
      prng_ack = 1'b0; restart = 1'b0;
      check("rst_mid_prng_req",   64'(prng_req_m),   64'd0);
      check("rst_mid_food_valid", 64'(food_valid_m), 64'd0);
      check("rst_mid_place_done", 64'(place_done_m), 64'd0);
      check("rst_mid_board_full", 64'(board_full_m), 64'd0);
      check("rst_mid_food_row",   64'(food_row_m),   64'd0);
      check("rst_mid_food_col",   64'(food_col_m),   64'd0);
      repeat (5) tick();
      check("rst_mid_stays_idle", 64'(prng_req_m), 64'd0);

      // Full board -> FULL, no PRNG traffic
      expect_done("full", 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 0);
      request(64'hFFFF_FFFF_FFFF_FFFF);
      wait_done("full");
      tick();
      check("full_hold_board_full", 64'(board_full_m), 64'd1);
      check("full_hold_food_valid", 64'(food_valid_m), 64'd0);

      // MAX_RETRIES=2 instance
      sel = 1'b1;
      #1;
      expect_done("wrap_cand", 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 2);
      request(~64'h1);
      serve("wrap_cand_a", 6'd62);
      serve("wrap_cand_b", 6'd63);
      wait_done("wrap_cand");

      expect_done("wrap_scan", 3'd0, 3'd2, 1'b1, 1'b1, 1'b0, 2);
      request(~64'h4);
      serve("wrap_scan_a", 6'd61);
      serve("wrap_scan_b", 6'd62);
      wait_done("wrap_scan");

      sel = 1'b0;
      #1;
      tick();

`ifdef FOOD_PRNG_TIMEOUT_EN
      // No ack: timeout after 16 cycles, scan from 0 -> index 1
      begin
         int hi = 0;
         expect_done("timeout", 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1);
         request(64'h1);
         while (prng_req_m === 1'b1 && hi < 100) begin
            tick();
            hi++;
         end
         check("timeout_req_cycles", 64'(hi), 64'd16);
         wait_done("timeout");
      end
`else
      // No ack: prng_req keeps waiting, then a late draw of 1
      expect_done("late_ack", 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1);
      request(64'h1);
      repeat (40) tick();
      check("late_ack_still_waiting", 64'(prng_req_m), 64'd1);
      serve("late_ack", 6'd1);
      wait_done("late_ack");
`endif

      repeat (3) tick();
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
